// File: rtl/wave_loader_pkg.sv
// Shared types for the wave-table loader: FSM state, latched load request and table depth.
package wave_loader_pkg;

  localparam int unsigned WL_NUM_OSC  = 4;
  localparam int unsigned WL_WW_WIDTH = 12;
  localparam int unsigned WL_MMEM_AW  = 18;
  localparam int unsigned BRAM_DEPTH  = 2 ** WL_WW_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWAP} wl_state_t;

  typedef struct packed {
    logic [WL_MMEM_AW-1:0]  start;
    logic [WL_WW_WIDTH:0]   width;
    logic [WL_NUM_OSC-1:0]  mask;
  } wl_req_t;

endpackage

// File: rtl/wave_table_bank.sv
// One oscillator's double-buffered wave table: the write port can fill either bank,
// playback reads the bank chosen by i_bank_sel through a two-stage, zero-when-off pipeline.
module wave_table_bank #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned WW_WIDTH     = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WW_WIDTH:0]       i_wr_addr,
  input  logic [SAMPLE_WIDTH-1:0] i_wr_data,
  input  logic                    i_wr_en,
  input  logic                    i_bank_sel,
  input  logic [WW_WIDTH-1:0]     i_rd_index,
  input  logic                    i_rd_en,
  output logic [SAMPLE_WIDTH-1:0] o_rd_data
);

  logic [SAMPLE_WIDTH-1:0] r_ram [2 ** (WW_WIDTH + 1)];
  logic [SAMPLE_WIDTH-1:0] r_rd_data;
  logic [SAMPLE_WIDTH-1:0] r_out;
  logic                    r_rd_on;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_ram[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_ram[{i_bank_sel, i_rd_index}];
  end

  // The on/off flag travels with the read so the zero lines up with its index.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rd_on <= 1'b0;
      r_out   <= '0;
    end else begin
      r_rd_on <= i_rd_en;
      r_out   <= r_rd_on ? r_rd_data : '0;
    end
  end

  assign o_rd_data = r_out;

endmodule

// File: rtl/wave_loader_mc.sv
// Multi-channel double-buffered wave-table loader: copies a main-memory window into the
// shadow bank of each selected oscillator, then swaps banks in a single cycle.
module wave_loader_mc
  import wave_loader_pkg::*;
#(
  parameter int unsigned NUM_OSCILLATORS = WL_NUM_OSC,
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned WW_WIDTH        = WL_WW_WIDTH,
  parameter int unsigned MMEM_AW         = WL_MMEM_AW,
  parameter int unsigned MMEM_LATENCY    = 2
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       ui_update_trig_in,
  input  logic [MMEM_AW-1:0]                         start_offset_in,
  input  logic [WW_WIDTH:0]                          wave_width_in,
  input  logic [NUM_OSCILLATORS-1:0]                 load_mask_in,
  output logic                                       busy_out,
  output logic                                       done_out,
  output logic                                       mmem_en_out,
  output logic [MMEM_AW-1:0]                         mmem_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]                    mmem_data_in,
  input  logic [NUM_OSCILLATORS-1:0]                 osc_is_on_in,
  input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]   osc_index_in,
  output logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_data_out,
  output logic [NUM_OSCILLATORS-1:0][WW_WIDTH:0]     osc_width_out,
  input  logic [$clog2(NUM_OSCILLATORS)-1:0]         viz_sel_in,
  input  logic [WW_WIDTH-1:0]                        viz_index_in,
  output logic [SAMPLE_WIDTH-1:0]                    viz_data_out
);

  localparam int unsigned CntW = WW_WIDTH + 1;

  wl_state_t r_state, w_state_d;
  wl_req_t   r_req, r_act, w_req_in, w_req_next;
  logic      r_pending, w_launch;
  logic [CntW-1:0] r_cnt;

  logic [MMEM_LATENCY-1:0] r_pipe_vld;
  logic [WW_WIDTH-1:0]     r_pipe_idx [MMEM_LATENCY];

  logic [NUM_OSCILLATORS-1:0]             r_bank_sel;
  logic [NUM_OSCILLATORS-1:0][WW_WIDTH:0] r_osc_width;
  logic [NUM_OSCILLATORS-1:0]             w_wr_en;
  logic [WW_WIDTH-1:0]                    w_wr_idx;

  logic [SAMPLE_WIDTH-1:0]            r_viz_rd [NUM_OSCILLATORS];
  logic [$clog2(NUM_OSCILLATORS)-1:0] r_viz_sel;
  logic [SAMPLE_WIDTH-1:0]            r_viz_data;

  always_comb begin
    w_req_in.start = start_offset_in;
    w_req_in.width = (wave_width_in > CntW'(BRAM_DEPTH)) ? CntW'(BRAM_DEPTH) : wave_width_in;
    w_req_in.mask  = load_mask_in;
    w_req_next     = ui_update_trig_in ? w_req_in : r_req;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_launch  = 1'b0;
    case (r_state)
      IDLE: begin
        if (ui_update_trig_in || r_pending) begin
          w_launch  = 1'b1;
          // Empty requests still acknowledge with a done pulse but never swap.
          w_state_d = (w_req_next.width == '0 || w_req_next.mask == '0) ? SWAP : FETCH;
        end
      end
      FETCH:   if (r_cnt == r_act.width - 1'b1) w_state_d = DRAIN;
      DRAIN:   if (r_cnt == CntW'(MMEM_LATENCY - 1)) w_state_d = SWAP;
      SWAP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out      = (r_state != IDLE);
    done_out      = (r_state == SWAP);
    mmem_en_out   = (r_state == FETCH);
    mmem_addr_out = '0;
    if (r_state == FETCH) mmem_addr_out = r_act.start + MMEM_AW'(r_cnt);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_req     <= '0;
      r_act     <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (ui_update_trig_in) r_req <= w_req_in;
      if (w_launch) begin
        r_act     <= w_req_next;
        r_pending <= 1'b0;
      end else if (ui_update_trig_in && r_state != IDLE) begin
        r_pending <= 1'b1;
      end
      r_cnt <= (r_state != w_state_d) ? '0 : r_cnt + 1'b1;
    end
  end

  // Delay line matching main-memory latency; its tail marks when mmem_data_in is valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < MMEM_LATENCY; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_pipe_vld[0] <= (r_state == FETCH);
      r_pipe_idx[0] <= r_cnt[WW_WIDTH-1:0];
      for (int i = 1; i < MMEM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  assign w_wr_idx = r_pipe_idx[MMEM_LATENCY-1];
  assign w_wr_en  = {NUM_OSCILLATORS{r_pipe_vld[MMEM_LATENCY-1]}} & r_act.mask;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_bank_sel  <= '0;
      r_osc_width <= '0;
    end else if (r_state == SWAP && r_act.width != '0) begin
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        if (r_act.mask[i]) begin
          r_bank_sel[i]  <= ~r_bank_sel[i];
          r_osc_width[i] <= r_act.width;
        end
      end
    end
  end

  assign osc_width_out = r_osc_width;

  for (genvar g = 0; g < NUM_OSCILLATORS; g++) begin : g_osc
    logic [SAMPLE_WIDTH-1:0] r_viz_ram [2 ** (WW_WIDTH + 1)];

    wave_table_bank #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .WW_WIDTH     (WW_WIDTH)
    ) u_bank (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_wr_addr  ({~r_bank_sel[g], w_wr_idx}),
      .i_wr_data  (mmem_data_in),
      .i_wr_en    (w_wr_en[g]),
      .i_bank_sel (r_bank_sel[g]),
      .i_rd_index (osc_index_in[g]),
      .i_rd_en    (osc_is_on_in[g]),
      .o_rd_data  (osc_data_out[g])
    );

    // Replica for the visualiser, since playback owns the table's only read port.
    always_ff @(posedge clk_in) begin
      if (w_wr_en[g]) r_viz_ram[{~r_bank_sel[g], w_wr_idx}] <= mmem_data_in;
      r_viz_rd[g] <= r_viz_ram[{r_bank_sel[g], viz_index_in}];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_viz_sel  <= '0;
      r_viz_data <= '0;
    end else begin
      r_viz_sel  <= viz_sel_in;
      r_viz_data <= r_viz_rd[r_viz_sel];
    end
  end

  assign viz_data_out = r_viz_data;

endmodule

// File: tb/tb_wave_loader_mc.sv
// Directed bench for wave_loader_mc: table of playback/visualiser reads plus hand-written
// sequences for load timing, glitch-free swap, wrap, clamp, retrigger and reset mid-load.
module tb_wave_loader_mc;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              trig = 1'b0;
  logic [17:0]       start = '0;
  logic [12:0]       width = '0;
  logic [3:0]        mask = '0;
  logic              busy_out, done_out, mmem_en_out;
  logic [17:0]       mmem_addr_out;
  logic [15:0]       mmem_data;
  logic [3:0]        osc_on = 4'hF;
  logic [3:0][11:0]  osc_index = '0;
  logic [3:0][15:0]  osc_data;
  logic [3:0][12:0]  osc_width;
  logic [1:0]        viz_sel = '0;
  logic [11:0]       viz_index = '0;
  logic [15:0]       viz_data;

  logic [15:0] mem [262144];
  logic [15:0] r_d1, r_d2;
  logic [17:0] addr_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Main-memory model with a fixed two-cycle read latency.
  always @(posedge clk) begin
    r_d1 <= mem[mmem_addr_out];
    r_d2 <= r_d1;
  end
  assign mmem_data = r_d2;

  wave_loader_mc u_dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .ui_update_trig_in (trig),
    .start_offset_in   (start),
    .wave_width_in     (width),
    .load_mask_in      (mask),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .mmem_en_out       (mmem_en_out),
    .mmem_addr_out     (mmem_addr_out),
    .mmem_data_in      (mmem_data),
    .osc_is_on_in      (osc_on),
    .osc_index_in      (osc_index),
    .osc_data_out      (osc_data),
    .osc_width_out     (osc_width),
    .viz_sel_in        (viz_sel),
    .viz_index_in      (viz_index),
    .viz_data_out      (viz_data)
  );

  typedef struct {
    int          osc;
    logic [11:0] idx;
    logic        on;
    logic [15:0] exp_osc;
    logic [1:0]  vsel;
    logic [11:0] vidx;
    logic [15:0] exp_viz;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input logic [17:0] st, input logic [12:0] w, input logic [3:0] m,
                          input int exp_done, input string name);
    int n;
    addr_q.delete();
    start = st; width = w; mask = m; trig = 1'b1;
    tick();
    trig = 1'b0;
    check({name, " busy"}, 32'(busy_out), 32'd1);
    n = 1;
    while (!done_out && n < 5000) begin
      if (mmem_en_out) addr_q.push_back(mmem_addr_out);
      tick();
      n++;
    end
    check({name, " done_at"}, done_out ? 32'(n) : 32'd0, 32'(exp_done));
    tick();
    check({name, " idle"}, 32'(busy_out), 32'd0);
  endtask

  task automatic read2(input int osc, input logic [11:0] idx);
    osc_index[osc] = idx;
    tick();
    tick();
  endtask

  initial begin
    int n, bad;
    int dpos [$];

    for (int k = 0; k < 262144; k++) mem[k] = 16'(k + 256);
    for (int k = 0; k < 8; k++) begin
      mem[32'h1000 + k] = 16'hAAAA;
      mem[32'h2000 + k] = 16'h5555;
    end
    for (int k = 0; k < 16; k++) mem[32'h3000 + k] = 16'(32'h7000 + k);

    vecs[0] = '{0, 12'd1,    1'b1, 16'h0121, 2'd2, 12'd5,    16'h0105};
    vecs[1] = '{1, 12'd3,    1'b1, 16'h0143, 2'd0, 12'd2,    16'h0122};
    vecs[2] = '{2, 12'd4095, 1'b1, 16'h10FF, 2'd3, 12'd1,    16'h00FF};
    vecs[3] = '{3, 12'd2,    1'b1, 16'h0100, 2'd1, 12'd0,    16'h0140};
    vecs[4] = '{2, 12'd4095, 1'b0, 16'h0000, 2'd2, 12'd4095, 16'h10FF};
    vecs[5] = '{3, 12'd0,    1'b1, 16'h00FE, 2'd3, 12'd3,    16'h0101};

    // Reset state
    tick();
    tick();
    check("rst busy", 32'(busy_out), 0);
    check("rst done", 32'(done_out), 0);
    check("rst mmem_en", 32'(mmem_en_out), 0);
    check("rst mmem_addr", 32'(mmem_addr_out), 0);
    check("rst osc_data", osc_data, 0);
    check("rst osc_width", 32'(osc_width), 0);
    check("rst viz", 32'(viz_data), 0);
    rst = 1'b1;
    tick();

    // Prime every table so untouched oscillators have known contents.
    run_load(18'h3000, 13'd16, 4'hF, 19, "prime");
    for (int i = 0; i < 4; i++) check("prime width", 32'(osc_width[i]), 32'd16);

    // Basic load
    run_load(18'h10, 13'd8, 4'b0001, 11, "basic");
    check("basic addr count", 32'(addr_q.size()), 32'd8);
    check("basic first addr", 32'(addr_q[0]), 32'h10);
    check("basic last addr", 32'(addr_q[7]), 32'h17);
    osc_index[1] = 12'd3;
    read2(0, 12'd3);
    check("basic osc0 idx3", 32'(osc_data[0]), 32'h0113);
    check("basic osc1 untouched", 32'(osc_data[1]), 32'h7003);
    check("basic width0", 32'(osc_width[0]), 32'd8);
    check("basic width1", 32'(osc_width[1]), 32'd16);

    // Glitch-free swap
    run_load(18'h1000, 13'd8, 4'b0001, 11, "old table");
    read2(0, 12'd2);
    check("glitch pre", 32'(osc_data[0]), 32'hAAAA);
    start = 18'h2000; width = 13'd8; mask = 4'b0001; trig = 1'b1;
    tick();
    trig = 1'b0;
    n = 1;
    bad = 0;
    while (!done_out && n < 100) begin
      if (osc_data[0] !== 16'hAAAA) bad++;
      tick();
      n++;
    end
    check("glitch done_at", 32'(n), 32'd11);
    check("glitch during load", 32'(bad), 0);
    check("glitch at done", 32'(osc_data[0]), 32'hAAAA);
    tick();
    check("glitch done+1", 32'(osc_data[0]), 32'hAAAA);
    tick();
    check("glitch done+2", 32'(osc_data[0]), 32'hAAAA);
    tick();
    check("glitch done+3 new", 32'(osc_data[0]), 32'h5555);

    // Address wrap
    run_load(18'h3FFFE, 13'd4, 4'b1000, 7, "wrap");
    check("wrap addr count", 32'(addr_q.size()), 32'd4);
    check("wrap addr0", 32'(addr_q[0]), 32'h3FFFE);
    check("wrap addr1", 32'(addr_q[1]), 32'h3FFFF);
    check("wrap addr2", 32'(addr_q[2]), 32'h0);
    check("wrap addr3", 32'(addr_q[3]), 32'h1);

    // Width clamp
    run_load(18'h0, 13'd5000, 4'b0100, 4099, "clamp");
    check("clamp addr count", 32'(addr_q.size()), 32'd4096);
    check("clamp width2", 32'(osc_width[2]), 32'd4096);

    // Retrigger mid-FETCH: two back-to-back loads, two done pulses
    start = 18'h20; width = 13'd8; mask = 4'b0001; trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    start = 18'h40; width = 13'd4; mask = 4'b0010; trig = 1'b1;
    tick();
    trig = 1'b0;
    n = 4;
    while (n < 40) begin
      if (done_out) dpos.push_back(n);
      tick();
      n++;
    end
    check("retrig done count", 32'(dpos.size()), 32'd2);
    if (dpos.size() == 2) begin
      check("retrig done1 at", 32'(dpos[0]), 32'd11);
      check("retrig done2 at", 32'(dpos[1]), 32'd19);
    end
    check("retrig width0", 32'(osc_width[0]), 32'd8);
    check("retrig width1", 32'(osc_width[1]), 32'd4);

    // Zero-width request: done pulse only, no bank toggle
    run_load(18'h3000, 13'd0, 4'b0100, 1, "w0");
    check("w0 width2 kept", 32'(osc_width[2]), 32'd4096);
    check("w0 width3 kept", 32'(osc_width[3]), 32'd4);

    // Playback, off gating and visualiser reads
    for (int v = 0; v < 6; v++) begin
      osc_on = 4'hF;
      osc_on[vecs[v].osc] = vecs[v].on;
      osc_index[vecs[v].osc] = vecs[v].idx;
      viz_sel = vecs[v].vsel;
      viz_index = vecs[v].vidx;
      tick();
      tick();
      check($sformatf("vec%0d osc%0d", v, vecs[v].osc), 32'(osc_data[vecs[v].osc]),
            32'(vecs[v].exp_osc));
      check($sformatf("vec%0d viz", v), 32'(viz_data), 32'(vecs[v].exp_viz));
    end
    osc_on = 4'hF;

    // Reset during FETCH aborts with no swap and clears bank selects
    start = 18'h10; width = 13'd8; mask = 4'b0001; trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    check("midrst pre busy", 32'(mmem_en_out), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst busy", 32'(busy_out), 0);
    check("midrst done", 32'(done_out), 0);
    check("midrst mmem_en", 32'(mmem_en_out), 0);
    check("midrst mmem_addr", 32'(mmem_addr_out), 0);
    check("midrst osc_data", osc_data, 0);
    check("midrst osc_width", 32'(osc_width), 0);
    check("midrst viz", 32'(viz_data), 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_out || busy_out) bad++;
    end
    check("midrst no resume", 32'(bad), 0);
    read2(0, 12'd7);
    check("midrst bank0 read", 32'(osc_data[0]), 32'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_loader_mc.md
Name: wave_loader_mc

Overview:
Multi-channel, double-buffered wave-table loader. On a UI trigger it copies a window of samples from external main memory into the shadow bank of each selected oscillator table. It then swaps banks atomically, so playback never reads a half-written table. Sits between main-memory/SD storage and the oscillator bank, and also feeds the HDMI visualiser through a selectable oscillator read port.

Parameters:
NUM_OSCILLATORS, 4, number of oscillator tables
SAMPLE_WIDTH, 16, sample width in bits
WW_WIDTH, 12, wave-width/index width; each bank holds BRAM_DEPTH = 2**WW_WIDTH samples
MMEM_AW, 18, main-memory address width; addresses wrap modulo 2**MMEM_AW
MMEM_LATENCY, 2, main-memory read latency in cycles (fixed, no stall)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous, active-low reset
ui_update_trig_in  in  1  load request, single-cycle pulse
start_offset_in  in  MMEM_AW  first main-memory address of window
wave_width_in  in  WW_WIDTH+1  samples to copy (0..BRAM_DEPTH)
load_mask_in  in  NUM_OSCILLATORS  oscillators to reload
busy_out  out  1  load in progress
done_out  out  1  one-cycle pulse on bank swap
mmem_en_out  out  1  main-memory read enable
mmem_addr_out  out  MMEM_AW  main-memory read address
mmem_data_in  in  SAMPLE_WIDTH  main-memory read data, valid MMEM_LATENCY cycles after enable
osc_is_on_in  in  NUM_OSCILLATORS  oscillator enable
osc_index_in  in  WW_WIDTH x NUM_OSCILLATORS  playback index per oscillator
osc_data_out  out  SAMPLE_WIDTH x NUM_OSCILLATORS  playback sample per oscillator
osc_width_out  out  (WW_WIDTH+1) x NUM_OSCILLATORS  width of each oscillator's active table
viz_sel_in  in  $clog2(NUM_OSCILLATORS)  oscillator shown on HDMI
viz_index_in  in  WW_WIDTH  visualiser index
viz_data_out  out  SAMPLE_WIDTH  visualiser sample

Behaviour:
- Reset (rst_in==0 at a clock edge):
  - Outputs: busy_out=0, done_out=0, mmem_en_out=0, mmem_addr_out=0, all osc_data_out=0, viz_data_out=0, all osc_width_out=0.
  - Internal: bank_sel all 0, pending=0, FSM=IDLE.
  - Reset mid-load aborts the load with no swap. Table contents are not cleared.
- Request capture: on a trigger, latch start_offset_in, load_mask_in and min(wave_width_in, BRAM_DEPTH) into a request register.
  - Trigger while busy (including the SWAP cycle): overwrite the request register and set pending. Last trigger wins; queue depth is one.
- FSM states:
  - IDLE: on a trigger or pending, go to FETCH and clear pending. If the latched width is 0 or the mask is 0, go to SWAP directly, skipping the fetch; SWAP then only pulses done_out, with no bank toggle.
  - FETCH: mmem_en_out=1, mmem_addr_out=(start+cnt) mod 2**MMEM_AW, cnt counts 0..W-1. After cnt=W-1, go to DRAIN.
  - DRAIN: hold MMEM_LATENCY cycles, then go to SWAP.
  - SWAP: for each masked oscillator, toggle bank_sel and load osc_width_out with W. Assert done_out for this one cycle, then go to IDLE.
- Write pipeline:
  - A shift register of MMEM_LATENCY stages carries valid and cnt.
  - When a stage exits valid, write mmem_data_in at address cnt into the inactive bank (~bank_sel) of each masked oscillator.
- Timing (trigger sampled at edge t, width W):
  - busy_out is 1 from t+1 through the SWAP cycle t+W+MMEM_LATENCY+1.
  - First address is issued at t+1; the last write lands at t+W+MMEM_LATENCY.
  - done_out is high at t+W+MMEM_LATENCY+1.
  - Reads issued after that edge see the new bank.
- Playback read path:
  - Address is {bank_sel[i], osc_index_in[i]}; latency 2 cycles, registered.
  - If osc_is_on_in[i] was 0 when the index was sampled, osc_data_out[i] is 0 two cycles later (the zero is pipelined).
  - Unmasked oscillators are untouched during a load.
- Visualiser path: reads oscillator viz_sel_in's active bank at viz_index_in, latency 2; viz_sel_in is pipelined with the index.
  - Design decision: the visualiser uses a dedicated replica RAM per oscillator, written alongside the oscillator tables, because each oscillator RAM's read port is already occupied by playback. Replicas may be dropped if BRAM budget demands it.
- Wrap-around: the main-memory address wraps modulo 2**MMEM_AW. Table indices never exceed W-1 during a load.

Decomposition:
- Package wave_loader_pkg holds:
  - localparam BRAM_DEPTH;
  - typedef enum {IDLE, FETCH, DRAIN, SWAP} wl_state_t;
  - request struct {start, width, mask}.
- Sub-module wave_table_bank: one oscillator's two-bank table built on the existing dual-port RAM primitive.
  - Ports: write (addr, data, we), bank_sel, read (index, en), zero-on-off output register.
  - Instantiated NUM_OSCILLATORS times via generate.
- Visualiser replica RAM plus viz_sel mux stay in the top.

Test Plan:
- Basic load: preload mmem[k]=k+0x100, start=0x10, W=8, mask=4'b0001 -> busy 1 cycle after trigger, done at trigger+11; osc0 index 3 then reads 0x113, osc_width_out[0]=8; osc1..3 unchanged.
- Glitch-free swap: osc0 plays the old table (value 0xAAAA) during a reload with 0x5555 -> osc_data_out[0] stays 0xAAAA until the edge after done, then 0x5555; never a mix.
- Wrap and clamp:
  - start=2**18-2, W=4 -> addresses 0x3FFFE, 0x3FFFF, 0x0, 0x1.
  - W=5000 -> clamped to 4096; done at trigger+4099.
- Retrigger and degenerate requests:
  - Second trigger (mask=4'b0010) mid-FETCH -> first load completes, then osc1 loads; two done pulses.
  - W=0 -> done pulse with no bank toggle.
- Reset mid-load: assert rst_in low during FETCH -> next cycle busy=0, all outputs 0, bank_sel all 0, no done pulse.
- Off gating and visualiser:
  - osc_is_on_in[2]=0 -> osc_data_out[2]=0 two cycles later.
  - viz_sel_in=2, index 5 -> viz_data_out = table 2 sample 5 after 2 cycles.
